// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with a one-entry decode buffer.
// Two-state control: REQ issues a request to imem, and WAIT holds until the response returns.
// A redirect from execute overrides everything. A response that was already in flight
// when the redirect arrived is marked with kill, so it is dropped instead of being
// delivered to decode.
module fetch_unit #(
  parameter int unsigned PC_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] pc_nxt,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam logic [0:0] ST_REQ  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]  state;
  logic        kill;
  logic [31:0] req_pc;

  logic space;
  logic req_fire;
  logic rsp_take;
  logic buf_load;

  // Redirect targets are word aligned, so the low two bits are deliberately ignored.
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^redirect_target[1:0];

  // A request is issued only when the buffer is free, or is being drained this cycle.
  // This guarantees that the buffer has room when the response returns.
  assign space          = !instr_valid || instr_ready;
  assign imem_req_valid = (state == ST_REQ) && space && !redirect_valid && rst;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_take       = (state == ST_WAIT) && imem_rsp_valid;
  assign buf_load       = rsp_take && !kill && !redirect_valid;

  // Next-PC selection: a redirect wins, then a sequential step on acceptance, otherwise hold.
  always_comb begin
    // NOTE: assign the default first, so that every path drives pc_nxt and no latch is inferred.
    pc_nxt = pc;
    if (rst) begin
      if (redirect_valid) begin
        pc_nxt = {redirect_target[31:2], 2'b00};
      end else if (req_fire) begin
        pc_nxt = pc + 32'(PC_STEP);
      end
    end
  end

  // Control state and the kill flag for a response that was already in flight at redirect time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments, so all flops see pre-edge values.
      state <= ST_REQ;
      kill  <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          if (req_fire) state <= ST_WAIT;
        end
        default: begin
          if (imem_rsp_valid) begin
            state <= ST_REQ;
            kill  <= 1'b0;
          end else if (redirect_valid) begin
            kill <= 1'b1;
          end
        end
      endcase
    end
  end

  // Capture the address of the accepted request, so that the returning data can be tagged with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_pc <= '0;
    end else if (req_fire) begin
      req_pc <= pc;
    end
  end

  // One-entry decode buffer. Its contents stay stable while it is stalled, and a redirect flushes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      if (redirect_valid) begin
        instr_valid <= 1'b0;
      end else if (buf_load) begin
        instr_valid <= 1'b1;
      end else if (instr_valid && instr_ready) begin
        instr_valid <= 1'b0;
      end
      if (buf_load) begin
        instr    <= imem_rsp_data;
        instr_pc <= req_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit.
// The bench models the external pc register and an instruction memory.
// For a given address, the memory returns (addr ^ 32'h5A00_0000).
// Expected decode-side transactions are queued by the stimulus process.
// A separate monitor pops and compares them whenever decode consumes an entry.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  localparam logic [31:0] KEY = 32'h5A00_0000;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] pc_init;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic        auto_rsp;
  logic        auto_valid;
  logic [31:0] auto_data;
  logic        man_valid;
  logic [31:0] man_data;

  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];

  fetch_unit #(.PC_STEP(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .pc_nxt          (pc_nxt),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
  );

  assign imem_rsp_valid = auto_rsp ? auto_valid : man_valid;
  assign imem_rsp_data  = auto_rsp ? auto_data  : man_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External pc register. While reset is held, it is preloaded from pc_init.
  always @(posedge clk or negedge rst) begin
    if (!rst) pc <= pc_init;
    else      pc <= pc_nxt;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] d);
    exp_t e;
    e.pc   = p;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Memory responder: it returns data one cycle after each accepted request.
  initial begin
    logic        fire;
    logic [31:0] a;
    auto_valid = 1'b0;
    auto_data  = '0;
    forever begin
      @(negedge clk);
      fire = rst && imem_req_valid && imem_req_ready && auto_rsp;
      a    = imem_req_addr;
      @(posedge clk);
      #1;
      auto_valid = fire;
      auto_data  = fire ? (a ^ KEY) : 32'h0;
    end
  end

  // Scoreboard monitor: it compares every consumed decode entry against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pc", instr_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_instr_pc", instr_pc, e.pc);
          check("sb_instr",    instr,    e.data);
        end
      end
    end
  end

  // Watchdog timer.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst             = 1'b0;
    pc_init         = 32'h0;
    imem_req_ready  = 1'b1;
    instr_ready     = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    auto_rsp        = 1'b1;
    man_valid       = 1'b0;
    man_data        = '0;

    // Reset state. A redirect during reset must not move pc.
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_req_valid",   32'(imem_req_valid), 32'h0);
    check("rst_instr",       instr, 32'h0);
    check("rst_instr_pc",    instr_pc, 32'h0);
    check("rst_pc_nxt",      pc_nxt, 32'h0);

    // Sequential fetch of 0, 4 and 8.
    push(32'h0, 32'h5A00_0000);
    push(32'h4, 32'h5A00_0004);
    push(32'h8, 32'h5A00_0008);
    next_cycle();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk);                                    // C0
    check("seq_req_valid0", 32'(imem_req_valid), 32'h1);
    check("seq_addr0",      imem_req_addr, 32'h0);
    check("seq_pc_nxt0",    pc_nxt, 32'h4);
    next_cycle(); @(negedge clk);                      // C1
    check("seq_wait_req_valid", 32'(imem_req_valid), 32'h0);
    check("seq_wait_pc_nxt",    pc_nxt, 32'h4);
    next_cycle(); @(negedge clk);                      // C2
    check("seq_req_valid4", 32'(imem_req_valid), 32'h1);
    check("seq_addr4",      imem_req_addr, 32'h4);
    next_cycle();                                      // C3
    next_cycle(); @(negedge clk);                      // C4
    check("seq_addr8", imem_req_addr, 32'h8);
    next_cycle();                                      // C5

    // Decode stall for 5 cycles while the buffer holds the entry for 8.
    next_cycle();                                      // C6
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req_valid",   32'(imem_req_valid), 32'h0);
      check("stall_pc_nxt",      pc_nxt, 32'hC);
      check("stall_instr_valid", 32'(instr_valid), 32'h1);
      check("stall_instr_pc",    instr_pc, 32'h8);
      check("stall_instr",       instr, 32'h5A00_0008);
      if (i < 4) next_cycle();
    end
    push(32'hC, 32'h5A00_000C);
    next_cycle();                                      // C11
    instr_ready = 1'b1;
    @(negedge clk);
    check("unstall_addr", imem_req_addr, 32'hC);
    next_cycle();                                      // C12
    next_cycle(); @(negedge clk);                      // C13
    check("addr_0x10", imem_req_addr, 32'h10);

    // Redirect in WAIT to 0x103. The late response for 0x10 must be discarded.
    next_cycle();                                      // C14
    auto_rsp        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h103;
    @(negedge clk);
    check("rdw_pc_nxt",    pc_nxt, 32'h100);
    check("rdw_req_valid", 32'(imem_req_valid), 32'h0);
    next_cycle();                                      // C15
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rdw_still_wait", 32'(imem_req_valid), 32'h0);
    check("rdw_hold_pc",    pc_nxt, 32'h100);
    next_cycle();                                      // C16
    man_valid = 1'b1;
    man_data  = 32'h5A00_0010;
    push(32'h100, 32'h5A00_0100);
    next_cycle();                                      // C17
    man_valid = 1'b0;
    auto_rsp  = 1'b1;
    @(negedge clk);
    check("rdw_killed_valid", 32'(instr_valid), 32'h0);
    check("rdw_req_addr",     imem_req_addr, 32'h100);
    next_cycle();                                      // C18
    next_cycle();                                      // C19: request 0x104 is issued

    // Redirect in the same cycle as the response for 0x104.
    next_cycle();                                      // C20
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    @(negedge clk);
    check("rdr_pc_nxt", pc_nxt, 32'h200);
    push(32'h200, 32'h5A00_0200);
    next_cycle();                                      // C21
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rdr_instr_valid", 32'(instr_valid), 32'h0);
    check("rdr_req_valid",   32'(imem_req_valid), 32'h1);
    check("rdr_req_addr",    imem_req_addr, 32'h200);
    next_cycle();                                      // C22
    next_cycle();                                      // C23: request 0x204 is issued

    // Reset asserted in WAIT abandons the request. The restart address is 0xFFFFFFFC.
    next_cycle();                                      // C24
    rst     = 1'b0;
    pc_init = 32'hFFFF_FFFC;
    next_cycle();
    @(negedge clk);
    check("rst2_instr_valid", 32'(instr_valid), 32'h0);
    check("rst2_req_valid",   32'(imem_req_valid), 32'h0);
    push(32'hFFFF_FFFC, 32'hA5FF_FFFC);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("wrap_addr",   imem_req_addr, 32'hFFFF_FFFC);
    check("wrap_pc_nxt", pc_nxt, 32'h0);
    next_cycle();                                      // WAIT; response arrives

    // Request not accepted for 3 cycles: the request is held, and it is accepted on the 4th.
    next_cycle();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_req_valid", 32'(imem_req_valid), 32'h1);
      check("bp_addr",      imem_req_addr, 32'h0);
      check("bp_pc_nxt",    pc_nxt, 32'h0);
      next_cycle();
    end
    imem_req_ready = 1'b1;
    push(32'h0, 32'h5A00_0000);
    @(negedge clk);
    check("bp_accept_valid", 32'(imem_req_valid), 32'h1);
    check("bp_accept_addr",  imem_req_addr, 32'h0);
    check("bp_accept_pc",    pc_nxt, 32'h4);
    next_cycle();
    instr_ready = 1'b0;
    next_cycle();
    instr_ready = 1'b1;
    @(negedge clk);
    next_cycle();
    instr_ready = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
